// File: rtl/dram_burst.sv
// Simple dual-port frame-buffer RAM: one write port plus a burst read port that streams
// consecutive words (wrapping at DEPTH) through an RD_LAT-deep {valid, last, data} pipeline.
module dram_burst #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DEPTH    = 307200,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned WR_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [LEN_W-1:0]  rd_len_i,
  output logic              rd_busy_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rlast_o,
  output logic              oob_err_o
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cur_q;
  logic [LEN_W-1:0]  rem_q;
  logic              oob_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] lst_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  logic waddr_ok;
  logic raddr_ok;
  logic issue;
  logic wr_hit;

  assign waddr_ok = {1'b0, waddr_i} < DepthExt;
  assign raddr_ok = {1'b0, rd_addr_i} < DepthExt;
  assign issue    = (state_q == StBurst);
  assign wr_hit   = (WR_FIRST != 0) && wen_i && (waddr_i == cur_q);

  always_ff @(posedge clk) begin
    if (wen_i && waddr_ok) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cur_q   <= '0;
      rem_q   <= '0;
      oob_q   <= 1'b0;
    end else begin
      if ((wen_i && !waddr_ok) || (state_q == StIdle && rd_req_i && !raddr_ok)) begin
        oob_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (rd_req_i && raddr_ok) begin
            cur_q   <= rd_addr_i;
            rem_q   <= rd_len_i;
            state_q <= StBurst;
          end
        end
        StBurst: begin
          cur_q <= (cur_q == LastAddr) ? '0 : cur_q + 1'b1;
          if (rem_q == '0) begin
            state_q <= StIdle;
          end else begin
            rem_q <= rem_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Data registers only load on a valid beat so rdata holds between bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      lst_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= issue;
      lst_q[0] <= issue && (rem_q == '0);
      if (issue) begin
        dat_q[0] <= wr_hit ? wdata_i : mem[cur_q];
      end
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign rd_busy_o = (state_q == StBurst);
  assign rvalid_o  = vld_q[RD_LAT-1];
  assign rlast_o   = lst_q[RD_LAT-1];
  assign rdata_o   = dat_q[RD_LAT-1];
  assign oob_err_o = oob_q;

endmodule
